// File: rtl/instruction_memory_prefetch.sv
// Program RAM with a program-load port and a self-sequencing prefetch FIFO feeding decode.
// Words leave as {instruction, pc} on a valid/ready handshake; a redirect flushes everything in flight.
module instruction_memory_prefetch #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_data,
  input  logic                  start,
  input  logic                  halt,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  instr_ready,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  fetching
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = PW + 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } state_t;

  // Decode handshake: a word transfers on a rising edge where instr_valid and
  // instr_ready are both high; while valid && !ready the head word and pc hold.
  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic                    inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0]   inflight_pc_q, inflight_pc_d;
  logic [CW-1:0]           count_q, count_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;

  logic [DATA_WIDTH-1:0]   mem_q       [DEPTH];
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic [DATA_WIDTH-1:0]   fifo_data_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   fifo_pc_q   [FIFO_DEPTH];

  logic in_fetch;
  logic flush;
  logic pop;
  logic push;
  logic issue;
  logic prog_wr;

  assign in_fetch = (state_q == S_FETCH);
  assign flush    = halt | redirect;
  assign prog_wr  = prog_we & ~in_fetch;
  assign pop      = (count_q != '0) & instr_ready & ~flush;
  assign push     = inflight_q & ~flush;
  // The in-flight read holds a FIFO slot, so a full FIFO can never be overrun.
  assign issue    = in_fetch & ~flush &
                    ((count_q + CW'(inflight_q)) < CW'(FIFO_DEPTH));

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = issue ? fetch_pc_q : inflight_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;

    if (halt) begin
      state_d = S_IDLE;
    end else if (redirect) begin
      state_d    = S_FETCH;
      fetch_pc_d = redirect_pc;
    end else if (start && !in_fetch) begin
      state_d = S_FETCH;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1);
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // RAM and FIFO storage carry no reset so program contents survive a reset.
  always_ff @(posedge clk) begin
    if (prog_wr) mem_q[prog_addr] <= prog_data;
    if (issue)   rd_data_q <= mem_q[fetch_pc_q];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= rd_data_q;
      fifo_pc_q[wr_ptr_q]   <= inflight_pc_q;
    end
  end

  always_comb begin
    instr_valid = (count_q != '0);
    instruction = instr_valid ? fifo_data_q[rd_ptr_q] : '0;
    instr_pc    = instr_valid ? fifo_pc_q[rd_ptr_q] : '0;
    fetching    = in_fetch;
  end

endmodule
